// File: rtl/rescale_row_buffer_if.sv
// rtl/rescale_row_buffer_if.sv - raster source pixel stream into the rescale row buffer
interface rescale_row_buffer_if #(
   parameter int PIX_W = 24
);
   logic [PIX_W-1:0] in_data;
   logic             in_valid;
   logic             in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/rescale_row_buffer.sv
// rtl/rescale_row_buffer.sv - two-bank source row ring with request-driven fill and bilinear neighbour reads
module rescale_row_buffer #(
   parameter int MAX_W = 640,
   parameter int PIX_W = 24
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [9:0]           src_width,
   input  logic [9:0]           src_height,
   rescale_row_buffer_if.slave  src,
   input  logic                 req,
   input  logic [9:0]           row_to_wait,
   output logic                 buffer_done,
   input  logic                 rd_en,
   input  logic [9:0]           rd_col,
   output logic [PIX_W-1:0]     neighbor0,
   output logic [PIX_W-1:0]     neighbor1,
   output logic [PIX_W-1:0]     neighbor2,
   output logic [PIX_W-1:0]     neighbor3,
   output logic                 seq_err,
   output logic [9:0]           rows_written
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL, S_READY} state_t;

   state_t     state, state_nxt;
   logic [9:0] width, height, col_wr, req_row, need;
   logic [10:0] req_p1, h_m1;
   logic       in_ready_c, beat, row_end, req_bad;
   logic [9:0] rd_c, rd_c1;

   logic [PIX_W-1:0] bank0 [MAX_W];
   logic [PIX_W-1:0] bank1 [MAX_W];

   assign req_p1  = {1'b0, req_row} + 11'd1;
   assign h_m1    = {1'b0, height} - 11'd1;
   assign need    = (req_p1 > h_m1) ? h_m1[9:0] : req_p1[9:0];
   assign beat    = src.in_valid & in_ready_c;
   assign row_end = (col_wr == width - 10'd1);
   // A request whose top row is already two rows behind the writer has lost data to the ring.
   assign req_bad = (row_to_wait < req_row) | (row_to_wait >= height) |
                    (({1'b0, row_to_wait} + 11'd2) < {1'b0, rows_written});
   assign src.in_ready = in_ready_c;

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = S_WAIT;
      end else begin
         case (state)
            S_IDLE:  state_nxt = S_IDLE;
            S_WAIT:  if (req) state_nxt = S_FILL;
            S_FILL: begin
               if (req)
                  state_nxt = S_FILL;
               else if ((rows_written > need) || (beat && row_end && rows_written == need))
                  state_nxt = S_READY;
            end
            S_READY: if (req) state_nxt = S_FILL;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready_c  = 1'b0;
      buffer_done = 1'b0;
      case (state)
         S_FILL:  in_ready_c  = (rows_written <= need) && (rows_written < height);
         S_READY: buffer_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         width        <= '0;
         height       <= '0;
         col_wr       <= '0;
         rows_written <= '0;
         req_row      <= '0;
         seq_err      <= 1'b0;
      end else if (start) begin
         width        <= src_width;
         height       <= src_height;
         col_wr       <= '0;
         rows_written <= '0;
         req_row      <= '0;
         seq_err      <= 1'b0;
      end else begin
         if (beat) begin
            if (row_end) begin
               col_wr       <= '0;
               rows_written <= rows_written + 10'd1;
            end else begin
               col_wr <= col_wr + 10'd1;
            end
         end
         if (req && state != S_IDLE) begin
            req_row <= row_to_wait;
            if (req_bad) seq_err <= 1'b1;
         end
      end
   end

   // Row k lands in bank k[0], overwriting row k-2.
   always_ff @(posedge clock) begin
      if (beat && !reset && !start) begin
         if (rows_written[0]) bank1[col_wr] <= src.in_data;
         else                 bank0[col_wr] <= src.in_data;
      end
   end

   assign rd_c  = (rd_col > width - 10'd1) ? width - 10'd1 : rd_col;
   assign rd_c1 = (rd_c == width - 10'd1) ? rd_c : rd_c + 10'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         neighbor0 <= '0;
         neighbor1 <= '0;
         neighbor2 <= '0;
         neighbor3 <= '0;
      end else if (rd_en) begin
         neighbor0 <= req_row[0] ? bank1[rd_c]  : bank0[rd_c];
         neighbor1 <= req_row[0] ? bank1[rd_c1] : bank0[rd_c1];
         neighbor2 <= need[0]    ? bank1[rd_c]  : bank0[rd_c];
         neighbor3 <= need[0]    ? bank1[rd_c1] : bank0[rd_c1];
      end
   end

endmodule

// File: tb/tb_rescale_row_buffer.sv
// tb/tb_rescale_row_buffer.sv - randomized scenario bench against a raster-image reference model
module tb_rescale_row_buffer;
   localparam int MAX_W = 640;
   localparam int PIX_W = 24;

   logic             clock = 1'b0;
   logic             reset, start, req, rd_en;
   logic [9:0]       src_width, src_height, row_to_wait, rd_col;
   logic             buffer_done, seq_err;
   logic [9:0]       rows_written;
   logic [PIX_W-1:0] neighbor0, neighbor1, neighbor2, neighbor3;
   logic [PIX_W-1:0] nb [4];

   rescale_row_buffer_if #(.PIX_W(PIX_W)) s_if ();

   rescale_row_buffer #(.MAX_W(MAX_W), .PIX_W(PIX_W)) dut (
      .clock(clock), .reset(reset), .start(start),
      .src_width(src_width), .src_height(src_height), .src(s_if),
      .req(req), .row_to_wait(row_to_wait), .buffer_done(buffer_done),
      .rd_en(rd_en), .rd_col(rd_col),
      .neighbor0(neighbor0), .neighbor1(neighbor1),
      .neighbor2(neighbor2), .neighbor3(neighbor3),
      .seq_err(seq_err), .rows_written(rows_written)
   );

   always #5 clock = ~clock;

   assign nb[0] = neighbor0;
   assign nb[1] = neighbor1;
   assign nb[2] = neighbor2;
   assign nb[3] = neighbor3;

   int checks = 0;
   int errors = 0;

   // Reference: the whole source frame in raster order plus how much of it has been sent.
   int m_w, m_h, m_req, pix_idx;
   logic [PIX_W-1:0] src_q [$];

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic int exp_total(input int r);
      return (min2(r + 1, m_h - 1) + 1) * m_w;
   endfunction

   function automatic logic [PIX_W-1:0] exp_nb(input int k, input int col);
      int cc, c1, row, cl;
      cc  = min2(col, m_w - 1);
      c1  = min2(cc + 1, m_w - 1);
      row = (k < 2) ? m_req : min2(m_req + 1, m_h - 1);
      cl  = (k % 2 == 0) ? cc : c1;
      return src_q[row * m_w + cl];
   endfunction

   task automatic pulse_start(input int w, input int h);
      @(negedge clock);
      s_if.in_valid = 1'b0;
      start      = 1'b1;
      src_width  = 10'(w);
      src_height = 10'(h);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic new_frame(input int w, input int h, input bit rnd);
      m_w = w; m_h = h; m_req = 0; pix_idx = 0;
      src_q.delete();
      for (int i = 0; i < w * h; i++)
         src_q.push_back(rnd ? PIX_W'($urandom) : PIX_W'(i + 1));
      pulse_start(w, h);
   endtask

   task automatic pulse_req(input int r);
      @(negedge clock);
      req = 1'b1;
      row_to_wait = 10'(r);
      @(negedge clock);
      req = 1'b0;
      m_req = r;
   endtask

   task automatic stream_until_done(input int mode, output int beats, output int gap,
                                    output int cycles, output bit ok);
      int cyc, last;
      logic v;
      cyc = 0; last = -100; beats = 0; gap = -1; ok = 1'b0;
      while (cyc < 3000 && !ok) begin
         @(negedge clock);
         cyc++;
         if (buffer_done === 1'b1) begin
            ok  = 1'b1;
            gap = cyc - last;
         end else begin
            case (mode)
               0:       v = 1'b1;
               1:       v = cyc[0];
               default: v = 1'($urandom_range(0, 1));
            endcase
            s_if.in_valid = v;
            s_if.in_data  = (pix_idx < src_q.size()) ? src_q[pix_idx] : PIX_W'($urandom);
            if (v && s_if.in_ready === 1'b1) begin
               beats++; pix_idx++; last = cyc;
            end
         end
      end
      cycles = cyc;
      s_if.in_valid = 1'b0;
   endtask

   task automatic do_read(input int col);
      @(negedge clock);
      rd_en  = 1'b1;
      rd_col = 10'(col);
      @(negedge clock);
      rd_en  = 1'b0;
      rd_col = 10'($urandom_range(0, 15));
   endtask

   task automatic fill_and_check(input string name, input int mode);
      int beats, gap, cycles, expb;
      bit ok;
      expb = exp_total(m_req) - pix_idx;
      if (expb < 0) expb = 0;
      stream_until_done(mode, beats, gap, cycles, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL %s timeout: buffer_done never rose", name); end
      checks++;
      if (beats != expb) begin errors++; $display("FAIL %s beats: got %0d expected %0d", name, beats, expb); end
      if (expb > 0) begin
         checks++;
         if (gap != 1) begin errors++; $display("FAIL %s done_latency: got %0d expected 1", name, gap); end
      end else begin
         checks++;
         if (cycles != 1) begin errors++; $display("FAIL %s satisfied_low_cycles: got %0d expected 1", name, cycles); end
      end
      checks++;
      if (rows_written !== 10'(pix_idx / m_w)) begin
         errors++; $display("FAIL %s rows_written: got %0d expected %0d", name, rows_written, pix_idx / m_w);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; req = 1'b0; rd_en = 1'b0;
      src_width = '0; src_height = '0; row_to_wait = '0; rd_col = '0;
      s_if.in_valid = 1'b0; s_if.in_data = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready: got %b expected 0", s_if.in_ready); end
      checks++; if (buffer_done !== 1'b0) begin errors++; $display("FAIL reset buffer_done: got %b expected 0", buffer_done); end
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset seq_err: got %b expected 0", seq_err); end
      checks++; if (rows_written !== 10'd0) begin errors++; $display("FAIL reset rows_written: got %0d expected 0", rows_written); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (nb[k] !== '0) begin errors++; $display("FAIL reset neighbor%0d: got %h expected 0", k, nb[k]); end
      end
   endtask

   task automatic test_basic_fill;
      new_frame(4, 3, 1'b0);
      pulse_req(0);
      checks++; if (s_if.in_ready !== 1'b1) begin errors++; $display("FAIL basic first_fill_ready: got %b expected 1", s_if.in_ready); end
      fill_and_check("basic", 0);
      checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL basic ready_drop: got %b expected 0", s_if.in_ready); end
      do_read(3);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (nb[k] !== exp_nb(k, 3)) begin errors++; $display("FAIL basic read nb%0d: got %h expected %h", k, nb[k], exp_nb(k, 3)); end
      end
      @(negedge clock);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (nb[k] !== exp_nb(k, 3)) begin errors++; $display("FAIL basic hold nb%0d: got %h expected %h", k, nb[k], exp_nb(k, 3)); end
      end
   endtask

   task automatic test_advance_clamp;
      pulse_req(1);
      checks++; if (buffer_done !== 1'b0) begin errors++; $display("FAIL advance done_low: got %b expected 0", buffer_done); end
      fill_and_check("advance", 0);
      foreach (src_q[i]) if (i < 0) $display("unused");
      for (int c = 0; c < 6; c += 5) begin
         do_read(c);
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (nb[k] !== exp_nb(k, c)) begin errors++; $display("FAIL advance read c%0d nb%0d: got %h expected %h", c, k, nb[k], exp_nb(k, c)); end
         end
      end
      pulse_req(2);
      checks++; if (buffer_done !== 1'b0) begin errors++; $display("FAIL clamp done_low: got %b expected 0", buffer_done); end
      checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL clamp ready: got %b expected 0", s_if.in_ready); end
      fill_and_check("clamp", 0);
      do_read(1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (nb[k] !== exp_nb(k, 1)) begin errors++; $display("FAIL clamp read nb%0d: got %h expected %h", k, nb[k], exp_nb(k, 1)); end
      end
   endtask

   task automatic test_backpressure;
      new_frame(4, 3, 1'b0);
      pulse_req(0);
      fill_and_check("backpressure", 1);
      for (int c = 0; c < 4; c++) begin
         do_read(c);
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (nb[k] !== exp_nb(k, c)) begin errors++; $display("FAIL backpressure read c%0d nb%0d: got %h expected %h", c, k, nb[k], exp_nb(k, c)); end
         end
      end
   endtask

   task automatic test_error_flag;
      new_frame(4, 3, 1'b0);
      pulse_req(2);
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL err legal_req: got %b expected 0", seq_err); end
      pulse_req(1);
      checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL err backwards_req: got %b expected 1", seq_err); end
      repeat (5) @(negedge clock);
      checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL err sticky: got %b expected 1", seq_err); end
      new_frame(4, 3, 1'b0);
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL err start_clear: got %b expected 0", seq_err); end
      pulse_req(5);
      checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL err row_beyond_h: got %b expected 1", seq_err); end
   endtask

   task automatic test_abort_reset;
      int beats;
      new_frame(4, 3, 1'b0);
      pulse_req(0);
      beats = 0;
      for (int i = 0; i < 100 && beats < 6; i++) begin
         @(negedge clock);
         s_if.in_valid = 1'b1;
         s_if.in_data  = src_q[pix_idx];
         if (s_if.in_ready === 1'b1) begin beats++; pix_idx++; end
      end
      new_frame(2, 2, 1'b1);
      checks++; if (rows_written !== 10'd0) begin errors++; $display("FAIL abort rows_written: got %0d expected 0", rows_written); end
      checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL abort wait_ready: got %b expected 0", s_if.in_ready); end
      pulse_req(0);
      fill_and_check("abort", 2);
      do_read(1);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (nb[k] !== exp_nb(k, 1)) begin errors++; $display("FAIL abort read nb%0d: got %h expected %h", k, nb[k], exp_nb(k, 1)); end
      end
      new_frame(3, 3, 1'b1);
      pulse_req(0);
      @(negedge clock);
      s_if.in_valid = 1'b1;
      s_if.in_data  = src_q[0];
      @(negedge clock);
      s_if.in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL midreset in_ready: got %b expected 0", s_if.in_ready); end
      checks++; if (buffer_done !== 1'b0) begin errors++; $display("FAIL midreset buffer_done: got %b expected 0", buffer_done); end
      checks++; if (rows_written !== 10'd0) begin errors++; $display("FAIL midreset rows_written: got %0d expected 0", rows_written); end
      checks++; if (neighbor0 !== '0) begin errors++; $display("FAIL midreset neighbor0: got %h expected 0", neighbor0); end
      reset = 1'b0;
      pulse_req(0);
      checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL midreset idle_ignores_req: got %b expected 0", s_if.in_ready); end
   endtask

   task automatic test_start_req;
      new_frame(4, 2, 1'b0);
      pulse_req(0);
      fill_and_check("startreq_pre", 2);
      @(negedge clock);
      start = 1'b1; req = 1'b1; row_to_wait = 10'd0;
      src_width = 10'd4; src_height = 10'd2;
      pix_idx = 0; m_req = 0;
      @(negedge clock);
      start = 1'b0; req = 1'b0;
      s_if.in_valid = 1'b1;
      checks++; if (buffer_done !== 1'b0) begin errors++; $display("FAIL startreq done: got %b expected 0", buffer_done); end
      checks++; if (rows_written !== 10'd0) begin errors++; $display("FAIL startreq rows_written: got %0d expected 0", rows_written); end
      repeat (3) @(negedge clock);
      checks++; if (s_if.in_ready !== 1'b0) begin errors++; $display("FAIL startreq wait_ready: got %b expected 0", s_if.in_ready); end
      s_if.in_valid = 1'b0;
      pulse_req(0);
      fill_and_check("startreq_post", 0);
   endtask

   task automatic test_random_frames;
      int r, c;
      for (int f = 0; f < 7; f++) begin
         if (f == 6) new_frame(MAX_W, 2, 1'b1);
         else        new_frame($urandom_range(1, 16), $urandom_range(1, 6), 1'b1);
         r = 0;
         while (r <= m_h - 1) begin
            pulse_req(r);
            fill_and_check("random", (f == 6) ? 0 : 2);
            for (int n = 0; n < 3; n++) begin
               c = (n == 0) ? m_w - 1 : $urandom_range(0, m_w + 2);
               do_read(c);
               for (int k = 0; k < 4; k++) begin
                  checks++;
                  if (nb[k] !== exp_nb(k, c)) begin
                     errors++;
                     $display("FAIL random W%0d H%0d r%0d c%0d nb%0d: got %h expected %h", m_w, m_h, r, c, k, nb[k], exp_nb(k, c));
                  end
               end
            end
            r += $urandom_range(0, 1) + ((r == m_h - 1) ? 1 : 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_advance_clamp();
      test_backpressure();
      test_error_flag();
      test_abort_reset();
      test_start_req();
      test_random_frames();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rescale_row_buffer.md
# rescale_row_buffer

Source-side line buffer for the rescale IP: it accepts the incoming source image as a raster pixel stream and holds two source rows in a two-bank ring. The rescale controller names the top source row it needs next, and this block fills the buffer up to that row plus one, then asserts `buffer_done`. It also serves the four bilinear neighbours of any source column with one-cycle read latency, so the controller's datapath can compute each rescaled pixel.

## Interface
Parameters:
- `MAX_W`, 640: maximum source width in pixels; sets bank depth.
- `PIX_W`, 24: pixel width (R8 G8 B8).

Ports:
- `clock` in 1: single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse that begins a new frame and latches `src_width`/`src_height`.
- `src_width` in 10: source width W, 1..`MAX_W`.
- `src_height` in 10: source height H, ≥1.
- `in_data` in `PIX_W`: source pixel in raster order.
- `in_valid` in 1: upstream has a pixel.
- `in_ready` out 1: block accepts; a beat transfers when `in_valid & in_ready`.
- `req` in 1: one-cycle pulse; latches `row_to_wait`.
- `row_to_wait` in 10: requested top row r.
- `buffer_done` out 1: level; rows r and need = min(r+1, H-1) are resident.
- `rd_en` in 1: neighbour read strobe.
- `rd_col` in 10: source column c.
- `neighbor0..3` out `PIX_W` each:
  - `neighbor0` = (r, c)
  - `neighbor1` = (r, min(c+1, W-1))
  - `neighbor2` = (need, c)
  - `neighbor3` = (need, min(c+1, W-1))
- `seq_err` out 1: sticky protocol-error flag.
- `rows_written` out 10: debug count of complete rows stored.

## Operation
- Storage: bank[k[0]] holds source row k; depth `MAX_W`.
- Counters:
  - `col_wr` wraps at W-1.
  - `rows_written` increments on the beat where `col_wr` == W-1.
- States:
  - **IDLE**: `in_ready`=0, `buffer_done`=0. `start` → WAIT; on entry, latch W and H and clear `col_wr`, `rows_written`, and `req_row`.
  - **WAIT**: `req` → latch `req_row` = `row_to_wait` → FILL.
  - **FILL**: `in_ready` = (`rows_written` ≤ need) & (`rows_written` < H). This is combinational from registered counters, so no beat past row `need` is ever accepted. When `rows_written` > need → READY.
  - **READY**: `buffer_done`=1. `req` → latch the new row → FILL. This holds even if the new request is already satisfied; `buffer_done` then drops for exactly 1 cycle.
- Overwrite rule: writing row k evicts row k-2. This is legal because the writer never passes need = r+1.
- `seq_err` sets (sticky until `reset`/`start`) when any of these occur:
  - a new `row_to_wait` < the previous `req_row`;
  - `row_to_wait` ≥ H;
  - `row_to_wait` + 1 < `rows_written` - 1 (a required row is already evicted).
  - On error, the request is still latched and the block proceeds.
- Reads: when `rd_en` is high, the neighbours are registered from the current `req_row`/need banks. The column is clamped to W-1. Neighbours hold their value when `rd_en` is low.
- `start` in any state aborts the current frame and re-enters WAIT with the new W/H. Stored data is considered stale.
- `start` and `req` in the same cycle: `start` wins and `req` is ignored.
- `req` arriving during FILL re-latches the row. Fill continues against the new need.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready`=0, `buffer_done`=0, `seq_err`=0, `rows_written`=0;
  - `neighbor0..3`=0.
- `in_ready` may rise in the cycle after `req` is latched (first FILL cycle).
- `buffer_done` rises 1 cycle after the beat completing row `need`.
- Read latency: 1 cycle (`rd_en`/`rd_col` at edge n → `neighbor*` valid after edge n+1).
- A write and a read in the same cycle to the same bank/column never happens, because reads occur only in READY, when `in_ready`=0.
- Reset mid-frame: next cycle is IDLE with all outputs at reset values. The partial row is discarded.

## Test plan
- **Basic fill.** W=4, H=3, `start`, `req` r=0, stream pixels 0x000001..0x00000C with `in_valid` held.
  - Exactly 8 beats are accepted and `in_ready` drops.
  - `buffer_done`=1 one cycle after beat 8.
  - `rd_col`=3 → `neighbor0`=0x000004, `neighbor1`=0x000004, `neighbor2`=0x000008, `neighbor3`=0x000008.
- **Advance and edge clamp.** Continue the basic fill with `req` r=1.
  - `buffer_done` goes low, 4 beats (0x09..0x0C) are accepted, `buffer_done` rises.
  - `rd_col`=0 → `neighbor0`=0x05, `neighbor2`=0x09.
  - `req` r=2 → `buffer_done` returns after 1 low cycle with no beats accepted; need clamps to 2, so `neighbor2` = `neighbor0`.
- **Backpressure.** Toggle `in_valid` every other cycle in the basic fill.
  - Identical stored data.
  - `buffer_done` is delayed accordingly, with no duplicate or lost beats.
- **Error flag.** Issue `req` r=2, then `req` r=1.
  - `seq_err`=1 and stays high until the next `start`.
  - `req` r=5 with H=3 → `seq_err`=1.
- **Abort and reset.** Assert `start` mid-row 1 with W=2, H=2, then `req` 0.
  - `rows_written` restarts at 0.
  - 4 fresh beats give `buffer_done`.
  - Assert `reset` during FILL → `in_ready`=0 and `buffer_done`=0 the next cycle, and the state is IDLE.
- **Simultaneous start and req.** Pulse `start` and `req` in the same cycle.
  - `req` is ignored and the block sits in WAIT with `in_ready`=0.
